mem_port_arbiter: RTL and testbench

Round-robin arbiter and sequencer for the single shared main-memory port of the write-through cache system. Up to four requesters compete for the port: cache write-through buffer, cache refill, instruction fetch and a debug/loader port. The block grants one requester at a time and drives the 2-bit select of the shared 4:1 memory-port mux. It issues a one-cycle request strobe to memory, waits for completion with a watchdog timeout, and then returns a done or error pulse to the owner.

---
 rtl/mem_port_arbiter.sv | 108 ++++++++++
 tb/tb_mem_port_arbiter.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter and sequencer for the shared main-memory port.
// Grants one of four requesters, strobes mem_req for one cycle, waits for
// mem_ready under a watchdog and returns a done or err pulse to the owner.
module mem_port_arbiter #(
  parameter int unsigned SEL_WIDTH      = 2,
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned CNT_WIDTH      = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [3:0]           req,
  input  logic                 mem_ready,
  output logic [3:0]           grant,
  output logic [SEL_WIDTH-1:0] sel,
  output logic                 mem_req,
  output logic [3:0]           done,
  output logic                 err,
  output logic [1:0]           err_id,
  output logic                 busy
);

  localparam int unsigned IDX_W = 2;
  localparam logic [CNT_WIDTH-1:0] CNT_LIMIT = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t               state;
  logic [IDX_W-1:0]     ptr;
  logic [CNT_WIDTH-1:0] cnt;
  logic [IDX_W-1:0]     owner_idx;
  logic [IDX_W-1:0]     pick_idx;
  logic                 pick_valid;

  assign owner_idx = IDX_W'(sel);

  // First set request bit searching ptr, ptr+1, ptr+2, ptr+3 (mod 4)
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    for (int j = 3; j >= 0; j--) begin
      if (req[ptr + IDX_W'(j)]) begin
        pick_valid = 1'b1;
        pick_idx   = ptr + IDX_W'(j);
      end
    end
  end

  // Sequencer: IDLE -> ISSUE -> WAIT -> IDLE, with all outputs registered
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      ptr     <= '0;
      cnt     <= '0;
      grant   <= '0;
      sel     <= '0;
      mem_req <= 1'b0;
      done    <= '0;
      err     <= 1'b0;
      err_id  <= '0;
      busy    <= 1'b0;
    end else begin
      mem_req <= 1'b0;
      done    <= '0;
      err     <= 1'b0;
      case (state)
        IDLE: begin
          grant <= '0;
          if (pick_valid) begin
            grant   <= 4'b0001 << pick_idx;
            sel     <= SEL_WIDTH'(pick_idx);
            mem_req <= 1'b1;
            busy    <= 1'b1;
            state   <= ISSUE;
          end
        end
        ISSUE: begin
          // Memory cannot answer in the strobe cycle, so mem_ready is ignored
          cnt   <= '0;
          state <= WAIT;
        end
        WAIT: begin
          if (mem_ready) begin
            done  <= grant;
            grant <= '0;
            busy  <= 1'b0;
            ptr   <= owner_idx + IDX_W'(1);
            state <= IDLE;
          end else if (cnt == CNT_LIMIT) begin
            err    <= 1'b1;
            err_id <= owner_idx;
            grant  <= '0;
            busy   <= 1'b0;
            ptr    <= owner_idx + IDX_W'(1);
            state  <= IDLE;
          end else begin
            cnt <= cnt + CNT_WIDTH'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios with literal
// expectations, then randomized traffic checked against a transaction model.
module tb_mem_port_arbiter;

  localparam int TO = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic       mem_ready;
  logic [3:0] grant;
  logic [1:0] sel;
  logic       mem_req;
  logic [3:0] done;
  logic       err;
  logic [1:0] err_id;
  logic       busy;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  // Model state: owner (-1 when none), edges since grant, round-robin pointer
  int         m_owner;
  int         m_age;
  int         m_ptr;
  logic [3:0] e_grant;
  logic [1:0] e_sel;
  logic       e_mem_req;
  logic [3:0] e_done;
  logic       e_err;
  logic [1:0] e_err_id;
  logic       e_busy;

  mem_port_arbiter #(
    .SEL_WIDTH(2),
    .TIMEOUT_CYCLES(TO),
    .CNT_WIDTH(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req(req),
    .mem_ready(mem_ready),
    .grant(grant),
    .sel(sel),
    .mem_req(mem_req),
    .done(done),
    .err(err),
    .err_id(err_id),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner = -1; m_age = 0; m_ptr = 0;
    e_grant = '0; e_sel = '0; e_mem_req = 0; e_done = '0;
    e_err = 0; e_err_id = '0; e_busy = 0;
  endtask

  // Transaction-level model advanced once per rising edge
  task automatic model_step();
    bit found;
    int c;
    if (rst) begin
      model_reset();
      return;
    end
    e_mem_req = 0; e_done = '0; e_err = 0;
    if (m_owner < 0) begin
      e_grant = '0;
      found = 0;
      for (int j = 0; j < 4; j++) begin
        c = (m_ptr + j) % 4;
        if (!found && req[c]) begin
          found = 1; m_owner = c; m_age = 0;
          e_grant = 4'(1 << c); e_sel = 2'(c); e_mem_req = 1; e_busy = 1;
        end
      end
    end else begin
      m_age++;
      // age 1 is the strobe edge; age 2.. are waiting edges
      if (m_age >= 2 && (mem_ready || (m_age - 2 == TO - 1))) begin
        if (mem_ready) e_done = 4'(1 << m_owner);
        else begin
          e_err = 1; e_err_id = 2'(m_owner);
        end
        e_grant = '0; e_busy = 0;
        m_ptr = (m_owner + 1) % 4;
        m_owner = -1;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  // Compare every output against the model each cycle
  always @(negedge clk) begin
    if (chk_en) begin
      chk("grant", 8'(grant), 8'(e_grant));
      chk("sel", 8'(sel), 8'(e_sel));
      chk("mem_req", 8'(mem_req), 8'(e_mem_req));
      chk("done", 8'(done), 8'(e_done));
      chk("err", 8'(err), 8'(e_err));
      chk("err_id", 8'(err_id), 8'(e_err_id));
      chk("busy", 8'(busy), 8'(e_busy));
    end
  end

  // One full transaction with literal expectations; called just before the grant edge
  task automatic txn(input string tag, input logic [3:0] eg, input logic [1:0] es,
                     input int delay, input bit ready);
    step();
    chk({tag, "_grant"}, 8'(grant), 8'(eg));
    chk({tag, "_sel"}, 8'(sel), 8'(es));
    chk({tag, "_mreq_hi"}, 8'(mem_req), 8'd1);
    step();
    chk({tag, "_mreq_lo"}, 8'(mem_req), 8'd0);
    if (ready) begin
      for (int k = 2; k < delay; k++) begin
        step();
        chk({tag, "_wait_done"}, 8'(done), 8'd0);
      end
      mem_ready = 1'b1;
      step();
      mem_ready = 1'b0;
      chk({tag, "_done"}, 8'(done), 8'(eg));
      chk({tag, "_noerr"}, 8'(err), 8'd0);
      chk({tag, "_gnt0"}, 8'(grant), 8'd0);
      chk({tag, "_busy0"}, 8'(busy), 8'd0);
    end else begin
      for (int k = 0; k < TO - 1; k++) begin
        step();
        chk({tag, "_wait_err"}, 8'(err), 8'd0);
      end
      step();
      chk({tag, "_err"}, 8'(err), 8'd1);
      chk({tag, "_err_id"}, 8'(err_id), 8'(es));
      chk({tag, "_nodone"}, 8'(done), 8'd0);
      chk({tag, "_gnt0"}, 8'(grant), 8'd0);
    end
  endtask

  initial begin
    bit silent;
    rst = 1'b1; req = '0; mem_ready = 1'b0;
    model_reset();
    #3;
    chk("rst_grant", 8'(grant), 8'd0);
    chk("rst_busy", 8'(busy), 8'd0);
    chk("rst_sel", 8'(sel), 8'd0);
    step();
    rst = 1'b0;
    chk_en = 1'b1;

    // Single requester, ready three cycles after the strobe
    req = 4'b0001;
    txn("single", 4'b0001, 2'd0, 3, 1);
    req = '0;
    step();

    // All requesting: rotation starts at ptr=1
    req = 4'b1111;
    txn("rr1", 4'b0010, 2'd1, 2, 1);
    txn("rr2", 4'b0100, 2'd2, 2, 1);
    txn("rr3", 4'b1000, 2'd3, 2, 1);
    txn("rr4", 4'b0001, 2'd0, 2, 1);
    txn("rr5", 4'b0010, 2'd1, 2, 1);

    // ptr=2, requesters 0 and 1: search 2,3,0,1 picks 0
    req = 4'b0011;
    txn("wrap", 4'b0001, 2'd0, 2, 1);

    // Timeout on requester 3, then requester 0 wins next
    req = 4'b1000;
    txn("tmo", 4'b1000, 2'd3, 0, 0);
    req = 4'b1001;
    txn("after_tmo", 4'b0001, 2'd0, 2, 1);

    // mem_ready on the timeout threshold edge: done wins
    req = 4'b0100;
    txn("thresh", 4'b0100, 2'd2, TO + 1, 1);

    // Asynchronous reset in the middle of a wait
    req = 4'b0010;
    step(); step(); step();
    #2 rst = 1'b1;
    #1;
    chk("arst_grant", 8'(grant), 8'd0);
    chk("arst_busy", 8'(busy), 8'd0);
    chk("arst_sel", 8'(sel), 8'd0);
    chk("arst_mreq", 8'(mem_req), 8'd0);
    model_reset();
    step();
    rst = 1'b0;
    req = 4'b0100;
    step();
    chk("arst_regrant", 8'(grant), 8'h4);
    chk("arst_sel2", 8'(sel), 8'd2);

    // Randomized traffic against the model
    silent = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (cyc % 250 == 0) silent = ~silent;
      for (int i = 0; i < 4; i++) begin
        if (e_done[i] || (e_err && e_err_id == 2'(i))) req[i] = 1'b0;
        else if (!req[i] && ($urandom % 5 == 0)) req[i] = 1'b1;
      end
      if (m_owner >= 0 && ($urandom % 20 == 0)) req[m_owner] = 1'b0;
      mem_ready = silent ? ($urandom % 30 == 0) : ($urandom % 3 == 0);
      step();
    end

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
